uart_rx: RTL

Serial receive side of the CPU's UART link, complementing the existing `uart` transmit module. Recovers 8-N-1 frames from the `uart_rx` pin by mid-bit sampling, buffers bytes in a small FIFO and exposes them to the load/store unit as memory-mapped data and status words. Sits in the Memory Access stage next to the transmitter and the hardware counter.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 45 ++++
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: MMIO addresses, FSM states, status bits.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_8010;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_8014;

    localparam int STAT_VALID = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVR   = 2;
    localparam int STAT_FERR  = 3;
    localparam int STAT_PERR  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a pop frees room for a same-cycle push.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of 8-N-1 frames into a FWFT FIFO with sticky errors.
// Define UART_RX_PARITY_EN for 8-E-1 frames and a parity_err flag at status[4].
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic        rd_en,
    input  logic        clr_err,
    output logic [7:0]  rd_data,
    output logic        rx_valid,
    output logic        rx_full,
    output logic        overrun,
    output logic        frame_err,
    output logic [31:0] status
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1;
    logic            rxs;
    logic            rxs_q;
    rx_state_t       state;
    rx_state_t       state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_n;
    logic [7:0]      shift;
    logic [7:0]      shift_n;
    logic            tick;
    logic            push;
    logic            set_ferr;
    logic            set_ovr;
    logic            fifo_empty;
    logic            fifo_full;
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
    logic            par_bad_n;
    logic            parity_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_q <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rxs   <= sync1;
            rxs_q <= rxs;
        end
    end

    assign tick = (cnt == '0);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        push     = 1'b0;
        set_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
`endif
        unique case (state)
            S_IDLE: begin
                if (!rxs && rxs_q) begin
                    state_n = S_START;
                    cnt_n   = HALF_M1;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else if (!rxs) begin
                    state_n = S_DATA;
                    cnt_n   = FULL_M1;
                    bit_n   = 3'd0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    shift_n = {rxs, shift[7:1]};
                    cnt_n   = FULL_M1;
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    par_bad_n = (rxs != ^shift);
                    cnt_n     = FULL_M1;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    state_n  = S_IDLE;
                    push     = rxs;
                    set_ferr = !rxs;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
        end
    end

    // A pop on the stop-sample cycle makes room, so only an unpopped full FIFO overruns.
    assign set_ovr = push && fifo_full && !rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= set_ovr  | (overrun   & ~clr_err);
            frame_err <= set_ferr | (frame_err & ~clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= (push & par_bad) | (parity_err & ~clr_err);
        end
    end
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_en),
        .wdata (shift),
        .head  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid = !fifo_empty;
    assign rx_full  = fifo_full;

    always_comb begin
        status             = '0;
        status[STAT_VALID] = rx_valid;
        status[STAT_FULL]  = rx_full;
        status[STAT_OVR]   = overrun;
        status[STAT_FERR]  = frame_err;
`ifdef UART_RX_PARITY_EN
        status[STAT_PERR]  = parity_err;
`endif
    end

endmodule
